// File: rtl/sol32_pkg.sv
// Shared definitions for the sol32 data responder: timer register offsets, bit indices, FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package sol32_pkg;

    // Word offsets (byte offset >> 2) inside the timer MMIO window
    localparam logic [2:0] OFF_CTRL    = 3'd0;
    localparam logic [2:0] OFF_COUNT   = 3'd1;
    localparam logic [2:0] OFF_COMPARE = 3'd2;
    localparam logic [2:0] OFF_STATUS  = 3'd3;
    localparam logic [2:0] OFF_PRESC   = 3'd4;

    // CTRL / STATUS bit positions
    localparam int CTRL_EN         = 0;
    localparam int CTRL_AUTORELOAD = 1;
    localparam int CTRL_IRQEN      = 2;
    localparam int STATUS_PEND     = 0;

    // The window always spans 32 bytes so that offset 0x10 decodes without a
    // fault whether or not the prescaler register is built in.
    localparam logic [31:0] MMIO_SPAN   = 32'd32;
    localparam logic [31:0] COMPARE_RST = 32'hFFFF_FFFF;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } timer_state_t;

endpackage

// File: rtl/sol32_timer.sv
// Memory-mapped compare timer: CTRL/COUNT/COMPARE/STATUS(/PRESC) registers, IDLE/RUN FSM, IRQ pulse.
// Latency: register reads combinational; writes visible next cycle; o_irq one cycle after the match.
// Backpressure: none; every write strobe is accepted in the cycle it is presented.
// Ports: i_clk, i_rst_n (sync, active-low), i_wr (qualified write), i_off (word offset),
//        i_wdata, o_rdata (combinational read data), o_irq (registered pulse).
// Option: SOL32_TIMER_PRESCALER_EN adds PRESC at offset 0x10 and a tick prescaler.
import sol32_pkg::*;

module sol32_timer (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_wr,
    input  logic [2:0]  i_off,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_irq
);

    timer_state_t r_state, w_state_nxt;
    logic        r_en, r_ar, r_ie, r_pend, r_irq;
    logic [31:0] r_count, r_compare;
    logic        w_en_nxt, w_ar_nxt, w_ie_nxt, w_pend_nxt, w_irq_nxt;
    logic [31:0] w_count_nxt, w_compare_nxt;
    logic        w_tick, w_match;

`ifdef SOL32_TIMER_PRESCALER_EN
    logic [31:0] r_presc, r_psc_cnt, w_presc_nxt, w_psc_cnt_nxt;
    assign w_tick = (r_state == RUN) && (r_psc_cnt == r_presc);
`else
    assign w_tick = (r_state == RUN);
`endif

    // Match looks at the pre-increment COUNT and only on tick cycles
    assign w_match = w_tick && (r_count == r_compare);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_en      <= 1'b0;
            r_ar      <= 1'b0;
            r_ie      <= 1'b0;
            r_count   <= '0;
            r_compare <= COMPARE_RST;
            r_pend    <= 1'b0;
            r_irq     <= 1'b0;
`ifdef SOL32_TIMER_PRESCALER_EN
            r_presc   <= '0;
            r_psc_cnt <= '0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_en      <= w_en_nxt;
            r_ar      <= w_ar_nxt;
            r_ie      <= w_ie_nxt;
            r_count   <= w_count_nxt;
            r_compare <= w_compare_nxt;
            r_pend    <= w_pend_nxt;
            r_irq     <= w_irq_nxt;
`ifdef SOL32_TIMER_PRESCALER_EN
            r_presc   <= w_presc_nxt;
            r_psc_cnt <= w_psc_cnt_nxt;
`endif
        end
    end

    always_comb begin
        w_en_nxt      = r_en;
        w_ar_nxt      = r_ar;
        w_ie_nxt      = r_ie;
        w_count_nxt   = r_count;
        w_compare_nxt = r_compare;
        w_pend_nxt    = r_pend;
        w_irq_nxt     = 1'b0;

        // Timer progress first, so that software writes below override it
        if (w_tick) begin
            if (w_match) begin
                w_irq_nxt = r_ie;
                if (r_ar) w_count_nxt = '0;
                else      w_en_nxt    = 1'b0;   // one-shot: COUNT holds
            end else begin
                w_count_nxt = r_count + 32'd1;
            end
        end

        if (i_wr) begin
            case (i_off)
                OFF_CTRL: begin
                    w_en_nxt = i_wdata[CTRL_EN];
                    w_ar_nxt = i_wdata[CTRL_AUTORELOAD];
                    w_ie_nxt = i_wdata[CTRL_IRQEN];
                end
                OFF_COUNT:   w_count_nxt   = i_wdata;
                OFF_COMPARE: w_compare_nxt = i_wdata;
                OFF_STATUS:  if (i_wdata[STATUS_PEND]) w_pend_nxt = 1'b0;
                default: ;
            endcase
        end

        // A match in the same cycle as a W1C keeps PEND set
        if (w_match) w_pend_nxt = 1'b1;

        w_state_nxt = w_en_nxt ? RUN : IDLE;

`ifdef SOL32_TIMER_PRESCALER_EN
        w_presc_nxt   = r_presc;
        w_psc_cnt_nxt = r_psc_cnt;
        if (r_state == RUN) w_psc_cnt_nxt = w_tick ? 32'd0 : r_psc_cnt + 32'd1;
        if (i_wr && (i_off == OFF_PRESC)) begin
            w_presc_nxt   = i_wdata;
            w_psc_cnt_nxt = '0;
        end
        if (!w_en_nxt) w_psc_cnt_nxt = '0;
`endif
    end

    always_comb begin
        o_rdata = '0;
        case (i_off)
            OFF_CTRL:    o_rdata = {29'd0, r_ie, r_ar, r_en};
            OFF_COUNT:   o_rdata = r_count;
            OFF_COMPARE: o_rdata = r_compare;
            OFF_STATUS:  o_rdata = {31'd0, r_pend};
`ifdef SOL32_TIMER_PRESCALER_EN
            OFF_PRESC:   o_rdata = r_presc;
`endif
            default:     o_rdata = '0;
        endcase
    end

    assign o_irq = r_irq;

endmodule

// File: rtl/sol32_data_responder.sv
// sol32 core data-port responder: word RAM at 0, timer block at MMIO_BASE, privilege/unmapped faults.
// Latency: loads combinational (0 cycles); stores and register writes visible next cycle.
// Backpressure: none; the core is never stalled, faulting stores are dropped.
// Ports: Clock, Reset (sync active-low), Mode (1=user), WriteEnable, MemoryAddress, DataOut,
//        DataIn (load data), Interrupt (timer pulse), AccessFault (unmapped or user MMIO).
// Option: SOL32_TIMER_PRESCALER_EN enables the timer prescaler register (see sol32_timer).
import sol32_pkg::*;

module sol32_data_responder #(
    parameter int          RAM_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Mode,
    input  logic        WriteEnable,
    input  logic [31:0] MemoryAddress,
    input  logic [31:0] DataOut,
    output logic [31:0] DataIn,
    output logic        Interrupt,
    output logic        AccessFault
);

    localparam int          AW        = $clog2(RAM_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

    logic [31:0] r_ram [RAM_WORDS];

    logic          w_ram_hit, w_mmio_hit, w_mmio_ok, w_tmr_wr;
    logic [31:0]   w_mmio_off, w_tmr_rdata;
    logic [AW-1:0] w_ram_idx;

    assign w_ram_hit  = (MemoryAddress < RAM_BYTES);
    assign w_mmio_off = MemoryAddress - MMIO_BASE;
    assign w_mmio_hit = (MemoryAddress >= MMIO_BASE) && (w_mmio_off < MMIO_SPAN);
    // User mode may not touch the timer at all: no reads, no writes, no side effects
    assign w_mmio_ok  = w_mmio_hit && !Mode;
    assign w_tmr_wr   = WriteEnable && w_mmio_ok;
    assign w_ram_idx  = MemoryAddress[AW+1:2];

    assign AccessFault = !w_ram_hit && !w_mmio_ok;

    always_ff @(posedge Clock) begin
        if (WriteEnable && w_ram_hit) r_ram[w_ram_idx] <= DataOut;
    end

    always_comb begin
        DataIn = '0;
        if (w_ram_hit)      DataIn = r_ram[w_ram_idx];
        else if (w_mmio_ok) DataIn = w_tmr_rdata;
    end

    sol32_timer u_timer (
        .i_clk   (Clock),
        .i_rst_n (Reset),
        .i_wr    (w_tmr_wr),
        .i_off   (w_mmio_off[4:2]),
        .i_wdata (DataOut),
        .o_rdata (w_tmr_rdata),
        .o_irq   (Interrupt)
    );

endmodule

// File: tb/tb_sol32_data_responder.sv
// Directed self-checking bench for sol32_data_responder (default build, no prescaler).
// Latency: n/a.
// Backpressure: n/a.
module tb_sol32_data_responder;

    localparam logic [31:0] A_CTRL    = 32'hFFFF_0000;
    localparam logic [31:0] A_COUNT   = 32'hFFFF_0004;
    localparam logic [31:0] A_COMPARE = 32'hFFFF_0008;
    localparam logic [31:0] A_STATUS  = 32'hFFFF_000C;
    localparam logic [31:0] A_PRESC   = 32'hFFFF_0010;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        Mode = 1'b0;
    logic        WriteEnable = 1'b0;
    logic [31:0] MemoryAddress = '0;
    logic [31:0] DataOut = '0;
    logic [31:0] DataIn;
    logic        Interrupt;
    logic        AccessFault;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] rv;

    sol32_data_responder dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .Mode          (Mode),
        .WriteEnable   (WriteEnable),
        .MemoryAddress (MemoryAddress),
        .DataOut       (DataOut),
        .DataIn        (DataIn),
        .Interrupt     (Interrupt),
        .AccessFault   (AccessFault)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        MemoryAddress = addr;
        DataOut       = data;
        WriteEnable   = 1'b1;
        tick();
        WriteEnable   = 1'b0;
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] data);
        WriteEnable   = 1'b0;
        MemoryAddress = addr;
        #1;
        data = DataIn;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        Reset = 1'b0;
        tick(); tick();
        Reset = 1'b1;
        chk("rst_irq", {31'd0, Interrupt}, 32'd0);
        rd(A_CTRL, rv);    chk("rst_ctrl", rv, 32'd0);
        rd(A_COUNT, rv);   chk("rst_count", rv, 32'd0);
        rd(A_COMPARE, rv); chk("rst_compare", rv, 32'hFFFF_FFFF);
        rd(A_STATUS, rv);  chk("rst_status", rv, 32'd0);

        // RAM store/load
        wr(32'h10, 32'hDEAD_BEEF);
        wr(32'h14, 32'h1234_5678);
        wr(32'h0,  32'h1111_1111);
        rd(32'h10, rv); chk("ram_ld10", rv, 32'hDEAD_BEEF);
        chk("ram_af", {31'd0, AccessFault}, 32'd0);
        rd(32'h14, rv); chk("ram_ld14", rv, 32'h1234_5678);

        // Unmapped: load and dropped store (0x8000 aliases word 0 if not dropped)
        rd(32'h0000_8000, rv); chk("unm_data", rv, 32'd0);
        chk("unm_af", {31'd0, AccessFault}, 32'd1);
        wr(32'h0000_8000, 32'h0BAD_0BAD);
        rd(32'h0, rv);  chk("unm_ram0", rv, 32'h1111_1111);
        rd(32'h10, rv); chk("unm_ram10", rv, 32'hDEAD_BEEF);

        // Offset 0x10 without prescaler: reads 0, no fault
        wr(A_PRESC, 32'h55);
        rd(A_PRESC, rv); chk("presc_rd", rv, 32'd0);
        chk("presc_af", {31'd0, AccessFault}, 32'd0);

        // Privilege
        wr(A_COUNT, 32'd7);
        Mode = 1'b1;
        MemoryAddress = A_CTRL; DataOut = 32'd1; WriteEnable = 1'b1;
        #1;
        chk("usr_wr_af", {31'd0, AccessFault}, 32'd1);
        tick();
        WriteEnable = 1'b0;
        rd(A_COUNT, rv); chk("usr_rd_count", rv, 32'd0);
        chk("usr_rd_af", {31'd0, AccessFault}, 32'd1);
        rd(32'h10, rv);  chk("usr_ram", rv, 32'hDEAD_BEEF);
        chk("usr_ram_af", {31'd0, AccessFault}, 32'd0);
        Mode = 1'b0;
        rd(A_CTRL, rv);  chk("usr_ctrl0", rv, 32'd0);
        rd(A_COUNT, rv); chk("sup_count7", rv, 32'd7);

        // Auto-reload: COMPARE=5, pulse after 6 ticks, again 6 later
        wr(A_COUNT, 32'd0);
        wr(A_COMPARE, 32'd5);
        wr(A_CTRL, 32'd7);
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk($sformatf("ar1_quiet%0d", i), {31'd0, Interrupt}, 32'd0);
        end
        rd(A_COUNT, rv); chk("ar_count5", rv, 32'd5);
        tick();
        chk("ar1_pulse", {31'd0, Interrupt}, 32'd1);
        rd(A_COUNT, rv);  chk("ar_count0", rv, 32'd0);
        rd(A_STATUS, rv); chk("ar_pend", rv, 32'd1);
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk($sformatf("ar2_quiet%0d", i), {31'd0, Interrupt}, 32'd0);
        end
        tick();
        chk("ar2_pulse", {31'd0, Interrupt}, 32'd1);
        wr(A_CTRL, 32'd0);
        wr(A_STATUS, 32'd1);
        rd(A_STATUS, rv); chk("w1c", rv, 32'd0);

        // One-shot: COMPARE=3, CTRL=101
        wr(A_COUNT, 32'd0);
        wr(A_COMPARE, 32'd3);
        wr(A_CTRL, 32'd5);
        tick(); tick(); tick();
        chk("os_quiet", {31'd0, Interrupt}, 32'd0);
        tick();
        chk("os_pulse", {31'd0, Interrupt}, 32'd1);
        tick();
        chk("os_after", {31'd0, Interrupt}, 32'd0);
        tick(); tick();
        rd(A_CTRL, rv);   chk("os_ctrl", rv, 32'd4);
        rd(A_COUNT, rv);  chk("os_count", rv, 32'd3);
        rd(A_STATUS, rv); chk("os_pend", rv, 32'd1);

        // W1C of PEND in the match cycle: set wins
        wr(A_STATUS, 32'd1);
        wr(A_COUNT, 32'd0);
        wr(A_COMPARE, 32'd2);
        wr(A_CTRL, 32'd5);
        tick(); tick();
        wr(A_STATUS, 32'd1);
        chk("w1c_mc_irq", {31'd0, Interrupt}, 32'd1);
        rd(A_STATUS, rv); chk("w1c_mc_pend", rv, 32'd1);
        rd(A_CTRL, rv);   chk("w1c_mc_ctrl", rv, 32'd4);

        // Reset on the match edge: no pulse, timer cleared
        wr(A_COUNT, 32'd0);
        wr(A_COMPARE, 32'd3);
        wr(A_CTRL, 32'd7);
        tick(); tick(); tick();
        Reset = 1'b0;
        tick();
        chk("rst_mc_irq", {31'd0, Interrupt}, 32'd0);
        rd(A_COUNT, rv);  chk("rst_mc_count", rv, 32'd0);
        rd(A_STATUS, rv); chk("rst_mc_pend", rv, 32'd0);
        Reset = 1'b1;
        tick();
        chk("rst_mc_irq2", {31'd0, Interrupt}, 32'd0);
        rd(A_CTRL, rv);    chk("rst_mc_ctrl", rv, 32'd0);
        rd(A_COMPARE, rv); chk("rst_mc_cmp", rv, 32'hFFFF_FFFF);
        rd(32'h10, rv);    chk("rst_mc_ram", rv, 32'hDEAD_BEEF);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
